// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback block.
// Holds the result-source and destination-select encodings, the controller
// state encoding, the link register number and the datapath widths.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  // Result source select (regsrc)
  typedef enum logic [1:0] {
    SRC_ALU = 2'b00,
    SRC_MEM = 2'b01,
    SRC_PC2 = 2'b10,
    SRC_IMM = 2'b11
  } src_e;

  // Destination select (regdst): which instruction field names the register
  typedef enum logic [1:0] {
    DST_7_5  = 2'b00,
    DST_10_8 = 2'b01,
    DST_4_2  = 2'b10,
    DST_LINK = 2'b11
  } dst_e;

  // Controller state
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MEM_WAIT = 2'b01,
    HALTED   = 2'b10
  } state_e;

  localparam logic [REG_W-1:0] REG_LINK = 3'd7;

endpackage

// File: rtl/writeback_ctrl_if.sv
// Bundle of every non-clock signal of the writeback controller.
//   Upstream retire port : in_valid/in_ready handshake plus instruction,
//                          regdst, regwrt, regsrc, halt, alu_result,
//                          pc_plus2, imm.
//   Data-memory load port: mem_req, mem_addr, mem_ack, mem_rdata.
//   Register-file port   : wb_en, wb_reg, wb_data.
//   Status               : halted, err.
// master = environment side (pipeline, memory, register file);
// slave  = writeback controller side.
interface writeback_ctrl_if;
  import wb_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] instruction;
  logic [1:0]        regdst;
  logic              regwrt;
  logic [1:0]        regsrc;
  logic              halt;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] pc_plus2;
  logic [DATA_W-1:0] imm;

  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              wb_en;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;

  logic              halted;
  logic              err;

  modport master (
    output in_valid, instruction, regdst, regwrt, regsrc, halt,
           alu_result, pc_plus2, imm, mem_ack, mem_rdata,
    input  in_ready, mem_req, mem_addr, wb_en, wb_reg, wb_data, halted, err
  );

  modport slave (
    input  in_valid, instruction, regdst, regwrt, regsrc, halt,
           alu_result, pc_plus2, imm, mem_ack, mem_rdata,
    output in_ready, mem_req, mem_addr, wb_en, wb_reg, wb_data, halted, err
  );

endinterface

// File: rtl/mux4_1.sv
// Generic 4:1 multiplexer of width W.
//   sel        : 2-bit select
//   in0..in3   : data inputs, chosen by sel = 0..3
//   out        : selected input
module mux4_1 #(
  parameter int W = 16
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  output logic [W-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      2'd1:    out = in1;
      2'd2:    out = in2;
      2'd3:    out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/wb_timeout_counter.sv
// Load-timeout counter for the writeback controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return the count to zero (wins over en)
//   en         : advance the count by one
//   term       : count has reached TIMEOUT-1
module wb_timeout_counter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign term = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/writeback_ctrl.sv
// Writeback controller: write side of the register file read by decode.
// Accepts retiring instructions (in_valid/in_ready), resolves destination
// register and result source, sequences variable-latency loads from data
// memory, and emits a one-cycle register-file write pulse. Also owns the
// halt state and a sticky load-timeout error.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : writeback_ctrl_if.slave (retire, load, write and status ports)
// Parameters: TIMEOUT = cycles allowed in MEM_WAIT before a load is
// abandoned (>=2); CNT_W = timeout counter width, 2**CNT_W > TIMEOUT.
module writeback_ctrl
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  writeback_ctrl_if.slave   bus
);

  state_e            state_q, state_d;
  logic              accept;
  logic              wr_now, start_load, load_done, load_to;
  logic              cnt_term, cnt_clr, cnt_en;

  logic [REG_W-1:0]  dst_sel;
  logic [DATA_W-1:0] src_sel;

  logic              wb_en_p1;
  logic [REG_W-1:0]  wb_reg_p1;
  logic [DATA_W-1:0] wb_data_p1;
  logic [DATA_W-1:0] mem_addr_p1;
  logic [REG_W-1:0]  dst_lat;
  logic              regwrt_lat;
  logic              err_q;

  // Opcode bits outside the three register fields are not needed here.
  logic              unused_instr_bits;
  assign unused_instr_bits = ^{bus.instruction[15:11], bus.instruction[1:0]};

  mux4_1 #(.W(REG_W)) u_dst_mux (
    .sel (bus.regdst),
    .in0 (bus.instruction[7:5]),
    .in1 (bus.instruction[10:8]),
    .in2 (bus.instruction[4:2]),
    .in3 (REG_LINK),
    .out (dst_sel)
  );

  // The memory leg is never taken for immediate writes; loads return later.
  mux4_1 #(.W(DATA_W)) u_src_mux (
    .sel (bus.regsrc),
    .in0 (bus.alu_result),
    .in1 (bus.mem_rdata),
    .in2 (bus.pc_plus2),
    .in3 (bus.imm),
    .out (src_sel)
  );

  wb_timeout_counter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout (
    .clk   (clk),
    .rst_n (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (cnt_term)
  );

  assign bus.in_ready = (state_q == IDLE);
  assign bus.mem_req  = (state_q == MEM_WAIT);
  assign bus.halted   = (state_q == HALTED);
  assign accept       = bus.in_valid & bus.in_ready;

  // Counter only runs while a load is outstanding; it restarts from zero
  // on every new load because it is held clear everywhere else.
  assign cnt_en  = (state_q == MEM_WAIT);
  assign cnt_clr = (state_q != MEM_WAIT) | bus.mem_ack | cnt_term;

  always_comb begin
    state_d    = state_q;
    wr_now     = 1'b0;
    start_load = 1'b0;
    load_done  = 1'b0;
    load_to    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.halt) begin
            state_d = HALTED;
          end else if (bus.regsrc == SRC_MEM) begin
            state_d    = MEM_WAIT;
            start_load = 1'b1;
          end else begin
            wr_now = bus.regwrt;
          end
        end
      end
      MEM_WAIT: begin
        // Ack takes priority over a coincident timeout.
        if (bus.mem_ack) begin
          load_done = 1'b1;
          state_d   = IDLE;
        end else if (cnt_term) begin
          load_to = 1'b1;
          state_d = IDLE;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p1: registered write port, load context, error flag ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wb_en_p1    <= 1'b0;
      wb_reg_p1   <= '0;
      wb_data_p1  <= '0;
      mem_addr_p1 <= '0;
      dst_lat     <= '0;
      regwrt_lat  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      wb_en_p1 <= wr_now | (load_done & regwrt_lat);
      if (wr_now) begin
        wb_reg_p1  <= dst_sel;
        wb_data_p1 <= src_sel;
      end else if (load_done) begin
        wb_reg_p1  <= dst_lat;
        wb_data_p1 <= bus.mem_rdata;
      end
      if (start_load) begin
        mem_addr_p1 <= bus.alu_result;
        dst_lat     <= dst_sel;
        regwrt_lat  <= bus.regwrt;
      end
      if (load_to) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.wb_en    = wb_en_p1;
  assign bus.wb_reg   = wb_reg_p1;
  assign bus.wb_data  = wb_data_p1;
  assign bus.mem_addr = mem_addr_p1;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Self-checking bench for writeback_ctrl: directed cases followed by a
// randomized mix of register writes and loads, compared against a
// transaction-level reference model.
module tb_writeback_ctrl;

  localparam int TO = 16;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic err_exp;

  writeback_ctrl_if bus ();

  writeback_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which register and value a non-load retire writes.
  function automatic logic [2:0] model_reg(input logic [15:0] ins, input logic [1:0] rd);
    case (rd)
      2'd0:    return ins[7:5];
      2'd1:    return ins[10:8];
      2'd2:    return ins[4:2];
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [15:0] model_data(input logic [1:0] rs, input logic [15:0] a,
                                             input logic [15:0] p, input logic [15:0] i);
    case (rs)
      2'd0:    return a;
      2'd2:    return p;
      default: return i;
    endcase
  endfunction

  // Retire a non-load instruction; called at a falling edge, returns at the
  // next falling edge after checking the write it should produce.
  task automatic nl(input logic [15:0] ins, input logic [1:0] rd, input logic rw,
                    input logic [1:0] rs, input logic [15:0] a, input logic [15:0] p,
                    input logic [15:0] i);
    chk("nl_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.instruction = ins; bus.regdst = rd; bus.regwrt = rw;
    bus.regsrc = rs; bus.halt = 1'b0; bus.alu_result = a; bus.pc_plus2 = p; bus.imm = i;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("nl_wb_en", bus.wb_en, rw);
    if (rw) begin
      chk("nl_wb_reg", bus.wb_reg, model_reg(ins, rd));
      chk("nl_wb_data", bus.wb_data, model_data(rs, a, p, i));
    end
    chk("nl_mem_req", bus.mem_req, 0);
  endtask

  // Retire a load whose data arrives in the d-th cycle after acceptance.
  // d > TO means the memory never answers in time.
  task automatic ld(input logic [15:0] ins, input logic [1:0] rd, input logic rw,
                    input logic [15:0] a, input int d, input logic [15:0] rdata);
    int  lim;
    logic ok;
    lim = (d <= TO) ? d : TO;
    ok  = (d <= TO);
    chk("ld_ready0", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.instruction = ins; bus.regdst = rd; bus.regwrt = rw;
    bus.regsrc = 2'b01; bus.halt = 1'b0; bus.alu_result = a;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      chk("ld_req", bus.mem_req, 1);
      chk("ld_addr", bus.mem_addr, a);
      chk("ld_ready", bus.in_ready, 0);
      chk("ld_wb_en_wait", bus.wb_en, 0);
      // Offer ignored traffic while busy, with churned fields.
      bus.in_valid    = (k < lim);
      bus.halt        = 1'($urandom_range(0, 1));
      bus.instruction = 16'($urandom);
      bus.regdst      = 2'($urandom);
      bus.regwrt      = 1'($urandom);
      bus.alu_result  = 16'($urandom);
      bus.mem_ack     = (k == d);
      bus.mem_rdata   = (k == d) ? rdata : 16'($urandom);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.in_valid = 1'b0; bus.halt = 1'b0;
    if (!ok) err_exp = 1'b1;
    chk("ld_wb_en", bus.wb_en, ok && rw);
    if (ok && rw) begin
      chk("ld_wb_reg", bus.wb_reg, model_reg(ins, rd));
      chk("ld_wb_data", bus.wb_data, rdata);
    end
    chk("ld_req_done", bus.mem_req, 0);
    chk("ld_ready_done", bus.in_ready, 1);
    chk("ld_err", bus.err, err_exp);
  endtask

  initial begin
    logic [1:0]  rs;
    logic [15:0] ins;
    n_tests = 0; n_fail = 0; err_exp = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.instruction = 0; bus.regdst = 0; bus.regwrt = 0;
    bus.regsrc = 0; bus.halt = 0; bus.alu_result = 0; bus.pc_plus2 = 0; bus.imm = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_wb_en", bus.wb_en, 0);
    chk("rst_wb_reg", bus.wb_reg, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_err", bus.err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU write: [7:5]=3
    nl(16'h4060, 2'b00, 1'b1, 2'b00, 16'h1234, 16'h0, 16'h0);
    // Back-to-back: ALU->R1, PC+2->R7 via link select, IMM->R2
    nl(16'h0020, 2'b00, 1'b1, 2'b00, 16'h0001, 16'h0, 16'h0);
    nl(16'h0000, 2'b11, 1'b1, 2'b10, 16'h0, 16'h0102, 16'h0);
    nl(16'h0008, 2'b10, 1'b1, 2'b11, 16'h0, 16'h0, 16'hFF80);
    // Non-writing retire right after a write: pulse must end
    nl(16'hFFFF, 2'b01, 1'b0, 2'b00, 16'h5555, 16'h0, 16'h0);

    // Load to R5 via [10:8], answered in the 3rd cycle
    ld(16'h0500, 2'b01, 1'b1, 16'h0040, 3, 16'hBEEF);
    // Ack coinciding with the last permitted cycle: write, no error
    ld(16'h00C0, 2'b00, 1'b1, 16'h0080, TO, 16'hCAFE);
    // No answer: timeout error, no write
    ld(16'h0300, 2'b01, 1'b1, 16'h00A0, TO + 5, 16'h1111);

    // Stray ack while idle
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h7777;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("stray_ack_wb_en", bus.wb_en, 0);
    chk("err_sticky", bus.err, 1);

    // Write so wb_reg/wb_data are nonzero before the reset test
    nl(16'h00E0, 2'b00, 1'b1, 2'b11, 16'h0, 16'h0, 16'hA5A5);

    // Asynchronous reset in the middle of a load
    bus.in_valid = 1'b1; bus.regsrc = 2'b01; bus.regwrt = 1'b1; bus.halt = 1'b0;
    bus.alu_result = 16'h0C00; bus.regdst = 2'b00;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", bus.mem_req, 0);
    chk("arst_mem_addr", bus.mem_addr, 0);
    chk("arst_wb_reg", bus.wb_reg, 0);
    chk("arst_wb_data", bus.wb_data, 0);
    chk("arst_err", bus.err, 0);
    chk("arst_ready", bus.in_ready, 1);
    err_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("late_ack_wb_en", bus.wb_en, 0);
    chk("late_ack_req", bus.mem_req, 0);

    // Randomized mix
    for (int t = 0; t < 60; t++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        rs = 2'($urandom_range(0, 2));
        if (rs != 2'd0) rs = rs + 2'd1;
        nl(ins, 2'($urandom), 1'($urandom), rs, 16'($urandom), 16'($urandom), 16'($urandom));
      end else begin
        ld(ins, 2'($urandom), 1'($urandom), 16'($urandom),
           int'($urandom_range(1, TO + 2)), 16'($urandom));
      end
    end

    // Halt: permanent, later retires ignored
    bus.in_valid = 1'b1; bus.halt = 1'b1; bus.regwrt = 1'b1; bus.regsrc = 2'b00;
    @(negedge clk);
    bus.halt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("halt_halted", bus.halted, 1);
      chk("halt_ready", bus.in_ready, 0);
      chk("halt_wb_en", bus.wb_en, 0);
      chk("halt_req", bus.mem_req, 0);
      bus.regsrc = 2'($urandom);
      bus.mem_ack = 1'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
